// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// It carries a control bundle, a data bundle and the rs1/rs2/rd addresses
// between two stages. A two-entry skid buffer absorbs downstream stalls, so
// in_ready never depends combinationally on out_ready.
//
// Ports
//   clk           clock; all state updates on the rising edge
//   reset         synchronous, active-low reset
//   flush         kill every held entry (branch taken / hazard squash)
//   in_valid      upstream beat valid
//   in_ready      stage can accept a beat
//   in_ctrl       control bundle      (CTRL_W)
//   in_data       data bundle         (DATA_W)
//   in_rs1/rs2/rd register addresses  (REG_AW each)
//   out_valid     downstream beat valid
//   out_ready     downstream accepts
//   out_ctrl      registered control bundle; 0 while idle if ZERO_BUBBLE=1
//   out_data      registered data bundle
//   out_rs1/rs2/rd registered addresses for the forwarding/hazard units
//   bubble_count  saturating count of cycles with out_ready=1, out_valid=0
//   state_dbg     {main_valid, skid_valid}
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both high at that edge (accept = in_valid & in_ready,
// emit = out_valid & out_ready). Once valid is raised, the payload is held
// stable until that transfer happens. in_ready is the inverse of the skid
// flop, gated low while reset is asserted.
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int CTRL_W      = 8,
    parameter int DATA_W      = 260,
    parameter int REG_AW      = 5,
    parameter int ZERO_BUBBLE = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [REG_AW-1:0] out_rd,
    output logic [CNT_W-1:0]  bubble_count,
    output logic [1:0]        state_dbg
);

    // State encoding is literally {main_valid, skid_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b10,
        SKID  = 2'b11
    } state_t;

    state_t state_q;

    logic              main_valid;
    logic              skid_valid;
    logic              accept;
    logic              emit;

    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [REG_AW-1:0] skid_rs1;
    logic [REG_AW-1:0] skid_rs2;
    logic [REG_AW-1:0] skid_rd;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    assign main_valid = (state_q == FULL) || (state_q == SKID);
    assign skid_valid = (state_q == SKID);
    assign state_dbg  = state_q;

    assign out_valid  = main_valid;
    assign in_ready   = reset & ~skid_valid;

    assign accept     = in_valid & in_ready;
    assign emit       = out_valid & out_ready;

    // Handshake FSM with the main (output) register and the skid register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= EMPTY;
            out_ctrl  <= '0;
            out_data  <= '0;
            out_rs1   <= '0;
            out_rs2   <= '0;
            out_rd    <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
            skid_rs1  <= '0;
            skid_rs2  <= '0;
            skid_rd   <= '0;
        end else if (flush) begin
            // Any emit this cycle has already been sampled downstream; the
            // beat offered upstream is dropped.
            state_q <= EMPTY;
            if (ZERO_BUBBLE != 0) begin
                out_ctrl <= '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q  <= FULL;
                        out_ctrl <= in_ctrl;
                        out_data <= in_data;
                        out_rs1  <= in_rs1;
                        out_rs2  <= in_rs2;
                        out_rd   <= in_rd;
                    end
                end
                FULL: begin
                    case ({emit, accept})
                        2'b11: begin
                            out_ctrl <= in_ctrl;
                            out_data <= in_data;
                            out_rs1  <= in_rs1;
                            out_rs2  <= in_rs2;
                            out_rd   <= in_rd;
                        end
                        2'b10: begin
                            state_q <= EMPTY;
                            if (ZERO_BUBBLE != 0) begin
                                out_ctrl <= '0;
                            end
                        end
                        2'b01: begin
                            // Downstream stalled: park the new beat behind main.
                            state_q   <= SKID;
                            skid_ctrl <= in_ctrl;
                            skid_data <= in_data;
                            skid_rs1  <= in_rs1;
                            skid_rs2  <= in_rs2;
                            skid_rd   <= in_rd;
                        end
                        default: begin
                        end
                    endcase
                end
                SKID: begin
                    if (emit) begin
                        state_q  <= FULL;
                        out_ctrl <= skid_ctrl;
                        out_data <= skid_data;
                        out_rs1  <= skid_rs1;
                        out_rs2  <= skid_rs2;
                        out_rd   <= skid_rd;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

    // Bubble profiling: downstream was ready but got nothing. Flush does not
    // clear it; only reset does.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bubble_count <= '0;
        end else if (out_ready && !main_valid && (bubble_count != CNT_MAX)) begin
            bubble_count <= bubble_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Main instance (default parameters) is driven by directed scenarios and a
// randomized phase. The reference model is a FIFO of capacity two: its head
// is what the stage must present, in_ready is "fewer than two held", and
// flush/reset empty it. A second instance (CNT_W=3, ZERO_BUBBLE=0) covers
// counter saturation and control hold on idle.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int CTRL_W = 8;
    localparam int DATA_W = 260;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;
    localparam int BW     = CTRL_W + DATA_W + 3 * REG_AW;

    typedef logic [BW-1:0] beat_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance ----------------
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic [REG_AW-1:0] in_rs1, in_rs2, in_rd;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [REG_AW-1:0] out_rs1, out_rs2, out_rd;
    logic [CNT_W-1:0]  bubble_count;
    logic [1:0]        state_dbg;

    pipe_stage_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .REG_AW(REG_AW),
        .ZERO_BUBBLE(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .bubble_count(bubble_count), .state_dbg(state_dbg)
    );

    // ---------------- small instance ----------------
    logic        s_reset, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [7:0]  s_in_ctrl, s_out_ctrl;
    logic [15:0] s_in_data, s_out_data;
    logic [4:0]  s_in_rs1, s_in_rs2, s_in_rd, s_out_rs1, s_out_rs2, s_out_rd;
    logic [2:0]  s_bubble_count;
    logic [1:0]  s_state_dbg;

    pipe_stage_reg #(
        .CTRL_W(8), .DATA_W(16), .REG_AW(5), .ZERO_BUBBLE(0), .CNT_W(3)
    ) dut_s (
        .clk(clk), .reset(s_reset), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_ctrl(s_in_ctrl), .in_data(s_in_data),
        .in_rs1(s_in_rs1), .in_rs2(s_in_rs2), .in_rd(s_in_rd),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .out_rs1(s_out_rs1), .out_rs2(s_out_rs2), .out_rd(s_out_rd),
        .bubble_count(s_bubble_count), .state_dbg(s_state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    logic        model_ready = 1'b0;
    logic        mon_en      = 1'b0;
    logic        rst_prev    = 1'b0;
    int unsigned exp_bubble  = 0;

    task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk_beat(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                                      input logic [REG_AW-1:0] r1, input logic [REG_AW-1:0] r2,
                                      input logic [REG_AW-1:0] rd);
        return {c, d, r1, r2, rd};
    endfunction

    function automatic beat_t rand_beat();
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < 9; i++) begin
            d = {d[DATA_W-33:0], 32'($urandom)};
        end
        return mk_beat(8'($urandom), d, 5'($urandom), 5'($urandom), 5'($urandom));
    endfunction

    // ---------------- driver tasks ----------------
    // Drive one cycle of stimulus; at the edge, record what the model says
    // the stage took in.
    task automatic step(input logic v, input beat_t b, input logic ordy,
                        input logic fl, input logic rst, output logic acc);
        in_valid  = v;
        {in_ctrl, in_data, in_rs1, in_rs2, in_rd} = b;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(posedge clk);
        acc = rst && !fl && v && model_ready;
        if (!rst || fl) begin
            exp_q.delete();
        end else if (acc) begin
            exp_q.push_back(b);
        end
        #1;
    endtask

    task automatic send(input beat_t b, input logic ordy);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            step(1'b1, b, ordy, 1'b0, 1'b1, acc);
            n++;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout act=not_accepted exp=accepted at %0t", $time);
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        for (int i = 0; i < n; i++) begin
            step(1'b0, '0, ordy, 1'b0, 1'b1, acc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) rst_prev <= !reset;

    always @(negedge clk) begin
        int sz;
        if (mon_en) begin
            sz = exp_q.size();
            model_ready = reset && (sz < 2);
            check("in_ready", 300'(in_ready), 300'(model_ready));
            check("out_valid", 300'(out_valid), 300'(sz > 0));
            check("state_dbg", 300'(state_dbg), 300'({sz > 0, sz == 2}));
            if (sz > 0) begin
                check("out_beat", 300'({out_ctrl, out_data, out_rs1, out_rs2, out_rd}), 300'(exp_q[0]));
            end else begin
                check("out_ctrl_nop", 300'(out_ctrl), 300'(0));
            end
            check("bubble_count", 300'(bubble_count), 300'(exp_bubble));
            if (rst_prev) begin
                check("reset_payload", 300'({out_data, out_rs1, out_rs2, out_rd}), 300'(0));
            end
            // Advance the model to what the coming edge produces.
            if (sz > 0 && out_ready) begin
                void'(exp_q.pop_front());
            end
            if (!reset) begin
                exp_bubble = 0;
            end else if (out_ready && sz == 0 && exp_bubble < 65535) begin
                exp_bubble++;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic acc;
        logic v, ordy, fl, rst;

        in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        out_ready = 1'b1; flush = 1'b0; reset = 1'b0;

        s_reset = 1'b0; s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
        s_in_ctrl = '0; s_in_data = '0; s_in_rs1 = '0; s_in_rs2 = '0; s_in_rd = '0;

        // Reset for two cycles, then stream four beats.
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
        mon_en = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
        for (int k = 1; k <= 4; k++) begin
            send(mk_beat(8'hA5, DATA_W'(k), 5'd0, 5'd0, 5'(k)), 1'b1);
        end
        idle(5, 1'b1);

        // Stall into skid; beat 3 held upstream until released.
        send(mk_beat(8'h11, DATA_W'(1), 5'd1, 5'd1, 5'd1), 1'b0);
        send(mk_beat(8'h12, DATA_W'(2), 5'd2, 5'd2, 5'd2), 1'b0);
        step(1'b1, mk_beat(8'h13, DATA_W'(3), 5'd3, 5'd3, 5'd3), 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, mk_beat(8'h13, DATA_W'(3), 5'd3, 5'd3, 5'd3), 1'b0, 1'b0, 1'b1, acc);
        send(mk_beat(8'h13, DATA_W'(3), 5'd3, 5'd3, 5'd3), 1'b1);
        idle(4, 1'b1);

        // Flush while in SKID with beat 9 offered.
        send(mk_beat(8'h21, DATA_W'(5), 5'd5, 5'd5, 5'd5), 1'b0);
        send(mk_beat(8'h22, DATA_W'(6), 5'd6, 5'd6, 5'd6), 1'b0);
        step(1'b1, mk_beat(8'h29, DATA_W'(9), 5'd9, 5'd9, 5'd9), 1'b0, 1'b1, 1'b1, acc);
        idle(3, 1'b1);

        // Reset while in SKID, with flush and out_ready high.
        send(mk_beat(8'h31, DATA_W'(7), 5'd7, 5'd7, 5'd7), 1'b0);
        send(mk_beat(8'h32, DATA_W'(8), 5'd8, 5'd8, 5'd8), 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
        send(mk_beat(8'h33, DATA_W'(10), 5'd10, 5'd10, 5'd10), 1'b1);
        idle(2, 1'b1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 800; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            rst  = ($urandom_range(0, 49) != 0);
            step(v, rand_beat(), ordy, fl, rst, acc);
        end
        idle(4, 1'b1);

        // Small instance: saturation at 7 and control hold on idle.
        @(posedge clk); #2;
        check("s_reset_bubble", 300'(s_bubble_count), 300'(0));
        check("s_reset_valid", 300'(s_out_valid), 300'(0));
        check("s_reset_in_ready", 300'(s_in_ready), 300'(0));
        s_reset = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #2;
            if (i == 5) check("s_bubble_5", 300'(s_bubble_count), 300'(5));
        end
        check("s_bubble_sat", 300'(s_bubble_count), 300'(7));
        check("s_idle_in_ready", 300'(s_in_ready), 300'(1));
        check("s_idle_state", 300'(s_state_dbg), 300'(2'b00));
        s_in_valid = 1'b1; s_in_ctrl = 8'h3C; s_in_data = 16'hBEEF; s_in_rd = 5'd7;
        @(posedge clk); #2;
        s_in_valid = 1'b0; s_in_ctrl = 8'h00; s_in_data = 16'h0000; s_in_rd = 5'd0;
        check("s_beat_valid", 300'(s_out_valid), 300'(1));
        check("s_beat_ctrl", 300'(s_out_ctrl), 300'(8'h3C));
        check("s_beat_data", 300'(s_out_data), 300'(16'hBEEF));
        @(posedge clk); #2;
        check("s_after_valid", 300'(s_out_valid), 300'(0));
        check("s_hold_ctrl", 300'(s_out_ctrl), 300'(8'h3C));
        check("s_hold_rd", 300'(s_out_rd), 300'(5'd7));
        repeat (3) @(posedge clk);
        #2;
        check("s_hold_ctrl_late", 300'(s_out_ctrl), 300'(8'h3C));
        check("s_bubble_held", 300'(s_bubble_count), 300'(7));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
